// File: rtl/br_wport_arbiter.sv
// Round-robin arbiter sharing one register-file write port between an ALU (A) and a load (B) requester.
// Optional pending-write scoreboard on pend_mask is enabled by defining BRARB_SCOREBOARD_EN.
module br_wport_arbiter #(
    parameter int DW           = 32,
    parameter int AW           = 5,
    parameter int FIFO_DEPTH   = 2,
    parameter int ZERO_PROTECT = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 a_valid,
    output logic                 a_ready,
    input  logic [AW-1:0]        a_addr,
    input  logic [DW-1:0]        a_data,
    input  logic                 b_valid,
    output logic                 b_ready,
    input  logic [AW-1:0]        b_addr,
    input  logic [DW-1:0]        b_data,
    output logic [AW-1:0]        WA,
    output logic [DW-1:0]        Din,
    output logic                 RegWrite,
    output logic                 grant_src,
    output logic                 idle,
    output logic [(2**AW)-1:0]   pend_mask
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
    localparam logic SRC_A = 1'b0;
    localparam logic SRC_B = 1'b1;

    logic [AW-1:0] addr_mem_q [2][FIFO_DEPTH];
    logic [DW-1:0] data_mem_q [2][FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q [2];
    logic [PW-1:0] wr_ptr_d [2];
    logic [PW-1:0] rd_ptr_q [2];
    logic [PW-1:0] rd_ptr_d [2];
    logic [CW-1:0] cnt_q [2];
    logic [CW-1:0] cnt_d [2];

    logic [1:0]    in_valid;
    logic [AW-1:0] in_addr [2];
    logic [DW-1:0] in_data [2];
    logic [1:0]    ready;
    logic [1:0]    nonempty;
    logic [1:0]    push;
    logic [1:0]    pop;

    logic          last_q, last_d;
    logic          gnt_any;
    logic          gnt_src;
    logic [AW-1:0] head_addr;
    logic [DW-1:0] head_data;
    logic          issue;

    logic          rw_q, rw_d;
    logic [AW-1:0] wa_q, wa_d;
    logic [DW-1:0] din_q, din_d;
    logic          gs_q, gs_d;

    always_comb begin
        in_valid   = {b_valid, a_valid};
        in_addr[0] = a_addr;
        in_addr[1] = b_addr;
        in_data[0] = a_data;
        in_data[1] = b_data;
        for (int unsigned s = 0; s < 2; s++) begin
            ready[s]    = (cnt_q[s] != FULL_CNT);
            nonempty[s] = (cnt_q[s] != '0);
            push[s]     = in_valid[s] & ready[s];
        end
    end

    // On a tie the source opposite the last grant wins; last_q resets to B so A wins first.
    always_comb begin
        gnt_any = |nonempty;
        case (nonempty)
            2'b01:   gnt_src = SRC_A;
            2'b10:   gnt_src = SRC_B;
            2'b11:   gnt_src = ~last_q;
            default: gnt_src = SRC_A;
        endcase
        pop[0]    = gnt_any && (gnt_src == SRC_A);
        pop[1]    = gnt_any && (gnt_src == SRC_B);
        head_addr = addr_mem_q[gnt_src][rd_ptr_q[gnt_src]];
        head_data = data_mem_q[gnt_src][rd_ptr_q[gnt_src]];
        issue     = gnt_any && !((ZERO_PROTECT != 0) && (head_addr == '0));
    end

    always_comb begin
        for (int unsigned s = 0; s < 2; s++) begin
            cnt_d[s]    = cnt_q[s] + CW'(push[s]) - CW'(pop[s]);
            wr_ptr_d[s] = push[s] ? wr_ptr_q[s] + PW'(1) : wr_ptr_q[s];
            rd_ptr_d[s] = pop[s]  ? rd_ptr_q[s] + PW'(1) : rd_ptr_q[s];
        end
        last_d = gnt_any ? gnt_src : last_q;
        gs_d   = gnt_any ? gnt_src : gs_q;
        rw_d   = issue;
        wa_d   = issue ? head_addr : wa_q;
        din_d  = issue ? head_data : din_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '{default: '0};
            wr_ptr_q <= '{default: '0};
            rd_ptr_q <= '{default: '0};
            last_q   <= SRC_B;
            rw_q     <= 1'b0;
            wa_q     <= '0;
            din_q    <= '0;
            gs_q     <= SRC_A;
        end else begin
            cnt_q    <= cnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            last_q   <= last_d;
            rw_q     <= rw_d;
            wa_q     <= wa_d;
            din_q    <= din_d;
            gs_q     <= gs_d;
        end
    end

    // Storage needs no reset: only entries inside the count window are ever read.
    always_ff @(posedge clk) begin
        for (int unsigned s = 0; s < 2; s++) begin
            if (push[s]) begin
                addr_mem_q[s][wr_ptr_q[s]] <= in_addr[s];
                data_mem_q[s][wr_ptr_q[s]] <= in_data[s];
            end
        end
    end

    assign a_ready   = ready[0];
    assign b_ready   = ready[1];
    assign RegWrite  = rw_q;
    assign WA        = wa_q;
    assign Din       = din_q;
    assign grant_src = gs_q;
    assign idle      = (cnt_q[0] == '0) && (cnt_q[1] == '0) && !rw_q;

`ifdef BRARB_SCOREBOARD_EN
    logic [PW-1:0] slot;

    always_comb begin
        pend_mask = '0;
        slot      = '0;
        for (int unsigned s = 0; s < 2; s++) begin
            for (int unsigned k = 0; k < FIFO_DEPTH; k++) begin
                if (k < 32'(cnt_q[s])) begin
                    slot = rd_ptr_q[s] + PW'(k);
                    if (!((ZERO_PROTECT != 0) && (addr_mem_q[s][slot] == '0))) begin
                        pend_mask[addr_mem_q[s][slot]] = 1'b1;
                    end
                end
            end
        end
        if (rw_q) begin
            pend_mask[wa_q] = 1'b1;
        end
    end
`else
    assign pend_mask = '0;
`endif

endmodule
